// File: rtl/sprite_pkg.sv
// Shared types for the sprite overlay stage: colour and palette types plus the
// per-pixel sideband that travels down the pipeline next to the ROM fetch.
package sprite_pkg;
  localparam int RGB_W = 24;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef rgb_t palette_t [0:15];

  // sprite placement, frozen once per frame
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       flip;
  } shadow_t;

  // sideband that has to stay aligned with the ROM data
  typedef struct packed {
    logic hs;
    logic vs;
    rgb_t bg;
  } pix_t;
endpackage

// File: rtl/sprite_bbox_addr.sv
// First pipeline stage: tests the raster position against the sprite box and
// registers the ROM address (mirrored when flip is set, zero on a miss).
module sprite_bbox_addr
  import sprite_pkg::*;
#(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_valid,
  input  logic [9:0]        i_pix_x,
  input  logic [9:0]        i_pix_y,
  input  shadow_t           i_spr,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_hit
);
  localparam int LW = $clog2(SPR_W);
  localparam int LH = $clog2(SPR_H);
  localparam logic [10:0] W11 = 11'(SPR_W);
  localparam logic [10:0] H11 = 11'(SPR_H);
  localparam logic [9:0]  HA  = 10'(H_ACT);
  localparam logic [9:0]  VA  = 10'(V_ACT);

  logic [10:0]   dx, dy;
  logic [LW-1:0] col;
  logic          hit;

  // 11-bit differences together with the >= guards keep a sprite near the
  // right/bottom edge from aliasing back onto the left/top of the screen
  always_comb begin
    dx  = {1'b0, i_pix_x} - {1'b0, i_spr.x};
    dy  = {1'b0, i_pix_y} - {1'b0, i_spr.y};
    hit = i_spr.en & i_pix_valid &
          (i_pix_x >= i_spr.x) & (dx < W11) &
          (i_pix_y >= i_spr.y) & (dy < H11) &
          (i_pix_x < HA) & (i_pix_y < VA);
    // SPR_W-1-dx on the low bits is just the bitwise complement
    col = i_spr.flip ? ~dx[LW-1:0] : dx[LW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rom_addr <= '0;
      o_hit      <= 1'b0;
    end else begin
      o_rom_addr <= hit ? {dy[LH-1:0], col} : '0;
      o_hit      <= hit;
    end
  end
endmodule

// File: rtl/sprite_pixel_compositor.sv
// Sprite overlay: shadowed sprite placement, 3-cycle pipeline around a
// synchronous sprite ROM, and the final palette/background mux.
module sprite_pixel_compositor
  import sprite_pkg::*;
#(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_valid,
  input  logic [9:0]        i_pix_x,
  input  logic [9:0]        i_pix_y,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  rgb_t              i_bg_rgb,
  input  logic [9:0]        i_spr_x,
  input  logic [9:0]        i_spr_y,
  input  logic              i_spr_en,
  input  logic              i_flip_h,
  input  palette_t          i_palette,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [IDX_W-1:0]  i_rom_idx,
  output rgb_t              o_rgb,
  output logic              o_valid,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_opaque
);
  localparam int STAGES = 3;
  localparam pix_t PIX_IDLE = '{hs: 1'b1, vs: 1'b1, bg: '0};

  shadow_t           shd;
  logic              vs_q;
  logic [STAGES:0]   vld_pipe;
  pix_t              s0, s1;
  logic              hit0, hit1;
  logic              opq;
  rgb_t              rgb_nxt;

  // placement only moves on the vsync falling edge so a frame never tears
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shd  <= '0;
      vs_q <= 1'b1;
    end else begin
      vs_q <= i_vsync;
      if (vs_q & ~i_vsync)
        shd <= '{x: i_spr_x, y: i_spr_y, en: i_spr_en, flip: i_flip_h};
    end
  end

  sprite_bbox_addr #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .H_ACT (H_ACT),
    .V_ACT (V_ACT),
    .ADDR_W(ADDR_W)
  ) u_bbox (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pix_valid(i_pix_valid),
    .i_pix_x    (i_pix_x),
    .i_pix_y    (i_pix_y),
    .i_spr      (shd),
    .o_rom_addr (o_rom_addr),
    .o_hit      (hit0)
  );

  assign vld_pipe[0] = i_pix_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe[STAGES:1] <= '0;
      s0                 <= PIX_IDLE;
      s1                 <= PIX_IDLE;
      hit1               <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      s0                 <= '{hs: i_hsync, vs: i_vsync, bg: i_bg_rgb};
      s1                 <= s0;
      hit1               <= hit0;
    end
  end

  // i_rom_idx is the ROM's answer to the address registered one stage earlier
  always_comb begin
    opq     = hit1 & (i_rom_idx != TRANSPARENT_IDX);
    rgb_nxt = '0;
    if (vld_pipe[STAGES-1])
      rgb_nxt = opq ? i_palette[i_rom_idx] : s1.bg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rgb    <= '0;
      o_opaque <= 1'b0;
      o_hsync  <= 1'b1;
      o_vsync  <= 1'b1;
    end else begin
      o_rgb    <= rgb_nxt;
      o_opaque <= opq;
      o_hsync  <= s1.hs;
      o_vsync  <= s1.vs;
    end
  end

  assign o_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Scoreboard bench: stimulus pushes expected outputs computed from a simple
// box/palette model; a negedge monitor pops and compares them.
module tb_sprite_pixel_compositor;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pix_valid, hsync, vsync, spr_en, flip_h;
  logic [9:0]  pix_x, pix_y, spr_x, spr_y;
  rgb_t        bg_rgb, o_rgb;
  palette_t    pal;
  logic [11:0] o_rom_addr;
  logic [3:0]  rom_q;
  logic        o_valid, o_hsync, o_vsync, o_opaque;

  sprite_pixel_compositor dut (
    .i_clk(clk), .i_rst(rst), .i_pix_valid(pix_valid), .i_pix_x(pix_x),
    .i_pix_y(pix_y), .i_hsync(hsync), .i_vsync(vsync), .i_bg_rgb(bg_rgb),
    .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_en(spr_en), .i_flip_h(flip_h),
    .i_palette(pal), .o_rom_addr(o_rom_addr), .i_rom_idx(rom_q),
    .o_rgb(o_rgb), .o_valid(o_valid), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_opaque(o_opaque)
  );

  logic [3:0] rom [0:4095];
  always @(posedge clk) rom_q <= rom[o_rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic v; logic [23:0] rgb; logic opq; logic hs; logic vs; } exp_t;
  typedef struct { int due; int addr; } aexp_t;
  exp_t  eq[$];
  aexp_t aq[$];
  exp_t  me;
  aexp_t ma;

  int m_sx, m_sy;
  bit m_en, m_flip, m_pvs;
  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].due <= cyc) begin
      me = eq.pop_front();
      chk("o_valid",  32'(o_valid),  32'(me.v));
      chk("o_rgb",    32'(o_rgb),    32'(me.rgb));
      chk("o_opaque", 32'(o_opaque), 32'(me.opq));
      chk("o_hsync",  32'(o_hsync),  32'(me.hs));
      chk("o_vsync",  32'(o_vsync),  32'(me.vs));
    end
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ma = aq.pop_front();
      chk("o_rom_addr", 32'(o_rom_addr), 32'(ma.addr));
    end
  end

  // one pixel per call; model shadow updates after the pixel is evaluated
  task automatic drive(bit v, int x, int y, bit hs, bit vs, logic [23:0] bg);
    exp_t e; aexp_t a; bit hit; int dx, dy, col, addr; logic [3:0] idx;
    pix_valid = v; pix_x = 10'(x); pix_y = 10'(y); hsync = hs; vsync = vs; bg_rgb = bg;
    dx = x - m_sx; dy = y - m_sy;
    hit  = v && m_en && dx >= 0 && dx < 64 && dy >= 0 && dy < 64;
    col  = m_flip ? 63 - dx : dx;
    addr = hit ? dy * 64 + col : 0;
    idx  = rom[addr];
    e.due = cyc + 3; e.v = v; e.hs = hs; e.vs = vs;
    e.opq = hit && idx != 4'd0;
    e.rgb = !v ? 24'h0 : (e.opq ? pal[idx] : bg);
    eq.push_back(e);
    a.due = cyc + 1; a.addr = addr;
    aq.push_back(a);
    if (m_pvs && !vs) begin
      m_sx = int'(spr_x); m_sy = int'(spr_y); m_en = spr_en; m_flip = flip_h;
    end
    m_pvs = vs;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 1, 24'h0);
  endtask

  task automatic vs_pulse();
    drive(0, 0, 0, 1, 0, 24'h0);
    drive(0, 0, 0, 1, 1, 24'h0);
  endtask

  task automatic push_rst(int due, bit with_addr);
    exp_t e; aexp_t a;
    e.due = due; e.v = 0; e.rgb = 24'h0; e.opq = 0; e.hs = 1; e.vs = 1;
    eq.push_back(e);
    if (with_addr) begin a.due = due; a.addr = 0; aq.push_back(a); end
  endtask

  task automatic do_reset();
    while (eq.size() > 0 && eq[$].due > cyc) void'(eq.pop_back());
    while (aq.size() > 0 && aq[$].due > cyc) void'(aq.pop_back());
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pix_valid = 1'($urandom); pix_x = 10'($urandom_range(0, 639));
      pix_y = 10'($urandom_range(0, 479)); vsync = 1'($urandom); hsync = 1'($urandom);
      push_rst(cyc + 1, 1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    push_rst(cyc + 1, 0);
    push_rst(cyc + 2, 0);
    m_sx = 0; m_sy = 0; m_en = 0; m_flip = 0; m_pvs = 1;
  endtask

  initial begin
    int x, y;
    bit vs_r;
    rst = 0; pix_valid = 0; pix_x = 0; pix_y = 0; hsync = 1; vsync = 1; bg_rgb = 0;
    spr_x = 0; spr_y = 0; spr_en = 0; flip_h = 0;
    for (int i = 0; i < 16; i++) pal[i] = 24'($urandom);
    for (int i = 0; i < 4096; i++) rom[i] = 4'd3;
    @(posedge clk); #1;
    do_reset();
    idle(8);

    pal[3] = 24'h83e23e;
    spr_x = 10'd100; spr_y = 10'd50; spr_en = 1;
    vs_pulse();
    drive(1, 100, 50, 1, 1, 24'h112233);
    drive(1, 164, 50, 1, 1, 24'h112233);
    drive(1, 163, 113, 1, 1, 24'h112233);
    drive(1, 100, 114, 1, 1, 24'h112233);
    drive(1, 99, 50, 1, 1, 24'h112233);
    idle(3);
    rom[0] = 4'd0;
    drive(1, 100, 50, 1, 1, 24'h112233);
    idle(3);
    rom[0] = 4'd3;
    spr_x = 10'd200;
    drive(1, 100, 50, 1, 1, 24'h112233);
    drive(1, 200, 50, 1, 1, 24'h112233);
    vs_pulse();
    drive(1, 100, 50, 1, 1, 24'h112233);
    drive(1, 200, 50, 1, 1, 24'h112233);

    spr_x = 0; spr_y = 0; flip_h = 1;
    vs_pulse();
    drive(1, 0, 0, 1, 1, 24'h445566);
    flip_h = 0;
    vs_pulse();
    drive(1, 0, 0, 1, 1, 24'h445566);
    drive(1, 5, 2, 1, 1, 24'h445566);

    spr_x = 10'd620; spr_y = 10'd470;
    vs_pulse();
    drive(1, 639, 479, 1, 1, 24'h778899);
    drive(0, 639, 479, 1, 1, 24'h778899);
    drive(1, 0, 0, 1, 1, 24'h778899);

    idle(3);
    for (int i = 0; i < 4096; i++) rom[i] = 4'($urandom);
    for (int i = 0; i < 16; i++) pal[i] = 24'($urandom);
    vs_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 19) == 0) begin
        spr_x = 10'($urandom_range(0, 639)); spr_y = 10'($urandom_range(0, 479));
        spr_en = ($urandom_range(0, 5) != 0); flip_h = 1'($urandom);
      end
      if ($urandom_range(0, 39) == 0) vs_r = ~vs_r;
      if ($urandom_range(0, 1) == 0) begin
        x = int'(spr_x) + int'($urandom_range(0, 70)) - 3;
        y = int'(spr_y) + int'($urandom_range(0, 70)) - 3;
      end else begin
        x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479));
      end
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      drive(bit'($urandom_range(0, 3) != 0), x, y, 1'($urandom), vs_r, 24'($urandom));
    end
    idle(6);
    for (int i = 0; i < 20 && (eq.size() > 0 || aq.size() > 0); i++) @(posedge clk);
    checks++;
    if (eq.size() > 0 || aq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, expected 0", eq.size() + aq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
